// File: rtl/pio_input_conditioner.sv
// -----------------------------------------------------------------------------
// pio_input_conditioner
//
// Board-side front end for the Nios system's input PIOs. Raw KEY/SW pins are
// synchronised with a two-flop chain per bit and then debounced. A new level is
// accepted only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
// The clean levels drive the button and switch PIOs. One-cycle
// press/release/change pulses are also produced for local fabric logic.
// Everything runs on the rising edge of clocks_ref_clk_clk.
//
// Ports
//   clocks_ref_clk_clk      in   system reference clock
//   clocks_ref_reset_reset  in   asynchronous, active-high reset
//   button_n_raw            in   raw KEY pins, 0 = pressed, asynchronous
//   switch_raw              in   raw SW pins, 1 = on, asynchronous
//   button_pio_export       out  debounced buttons, active-low (to button PIO)
//   switch_pio_export       out  debounced switches (to switch PIO)
//   button_press_pulse      out  1-cycle pulse on debounced 1->0 of a button
//   button_release_pulse    out  1-cycle pulse on debounced 0->1 of a button
//   switch_change_pulse     out  1-cycle pulse on any debounced switch change
//   any_event               out  OR of all pulse outputs, same cycle
// -----------------------------------------------------------------------------
module pio_input_conditioner #(
    parameter int N_BUTTONS       = 3,
    parameter int N_SWITCHES      = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clocks_ref_clk_clk,
    input  logic                  clocks_ref_reset_reset,
    input  logic [N_BUTTONS-1:0]  button_n_raw,
    input  logic [N_SWITCHES-1:0] switch_raw,
    output logic [N_BUTTONS-1:0]  button_pio_export,
    output logic [N_SWITCHES-1:0] switch_pio_export,
    output logic [N_BUTTONS-1:0]  button_press_pulse,
    output logic [N_BUTTONS-1:0]  button_release_pulse,
    output logic [N_SWITCHES-1:0] switch_change_pulse,
    output logic                  any_event
);

    // Buttons and switches share one debouncer vector: buttons occupy the low
    // bits, switches the high bits.
    localparam int N  = N_BUTTONS + N_SWITCHES;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Buttons idle released (1), switches idle off (0).
    localparam logic [N-1:0]  RST_VAL  = {{N_SWITCHES{1'b0}}, {N_BUTTONS{1'b1}}};
    localparam logic [CW-1:0] TERM_CNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  raw_all;
    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [N-1:0]  stable_q, stable_d;
    logic [N-1:0]  pulse_q, pulse_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    assign raw_all = {switch_raw, button_n_raw};

    always_comb begin
        sync1_d  = raw_all;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        pulse_d  = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                // Input agrees with the accepted level: any bounce restarts the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == TERM_CNT) begin
                // Held long enough: accept it and flag the transition for one cycle.
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                pulse_d[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clocks_ref_clk_clk or posedge clocks_ref_reset_reset) begin
        if (clocks_ref_reset_reset) begin
            sync1_q  <= RST_VAL;
            sync2_q  <= RST_VAL;
            stable_q <= RST_VAL;
            pulse_q  <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Every output comes from flops. The accepted level is visible in the same
    // cycle as its pulse, so the new button level tells a press from a release.
    assign button_pio_export    = stable_q[N_BUTTONS-1:0];
    assign switch_pio_export    = stable_q[N-1:N_BUTTONS];
    assign button_press_pulse   = pulse_q[N_BUTTONS-1:0] & ~stable_q[N_BUTTONS-1:0];
    assign button_release_pulse = pulse_q[N_BUTTONS-1:0] &  stable_q[N_BUTTONS-1:0];
    assign switch_change_pulse  = pulse_q[N-1:N_BUTTONS];
    assign any_event            = |pulse_q;

endmodule

// File: tb/tb_pio_input_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for pio_input_conditioner with DEBOUNCE_CYCLES = 4 (latency 6 edges).
// A reference model holds the history of levels the debouncer has seen, which
// are the raw pins delayed by two edges. A bit flips when the last D entries
// all differ from its accepted level. Directed scenarios are followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_pio_input_conditioner;

    localparam int NB = 3;
    localparam int NS = 10;
    localparam int D  = 4;
    localparam int N  = NB + NS;
    localparam logic [N-1:0] RST_VAL = {{NS{1'b0}}, {NB{1'b1}}};

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NS-1:0] sw_raw;
    logic [NB-1:0] button_pio_export;
    logic [NS-1:0] switch_pio_export;
    logic [NB-1:0] button_press_pulse;
    logic [NB-1:0] button_release_pulse;
    logic [NS-1:0] switch_change_pulse;
    logic          any_event;

    always #5 clk = ~clk;

    pio_input_conditioner #(
        .N_BUTTONS      (NB),
        .N_SWITCHES     (NS),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clocks_ref_clk_clk    (clk),
        .clocks_ref_reset_reset(rst),
        .button_n_raw          (btn_raw),
        .switch_raw            (sw_raw),
        .button_pio_export     (button_pio_export),
        .switch_pio_export     (switch_pio_export),
        .button_press_pulse    (button_press_pulse),
        .button_release_pulse  (button_release_pulse),
        .switch_change_pulse   (switch_change_pulse),
        .any_event             (any_event)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_stable;
    logic [N-1:0] m_pulse;
    logic [N-1:0] dl_q[$];    // two-edge pin delay
    logic [N-1:0] hist_q[$];  // last D levels seen by the debouncer

    function automatic void model_reset();
        m_stable = RST_VAL;
        m_pulse  = '0;
        dl_q     = '{RST_VAL, RST_VAL};
        hist_q.delete();
    endfunction

    function automatic void model_edge(input logic [N-1:0] raw);
        logic [N-1:0] seen;
        logic         all_diff;
        seen = dl_q.pop_front();
        dl_q.push_back(raw);
        hist_q.push_back(seen);
        if (hist_q.size() > D) void'(hist_q.pop_front());
        m_pulse = '0;
        if (hist_q.size() == D) begin
            for (int b = 0; b < N; b++) begin
                all_diff = 1'b1;
                foreach (hist_q[k]) if (hist_q[k][b] == m_stable[b]) all_diff = 1'b0;
                m_pulse[b] = all_diff;
            end
        end
        m_stable = m_stable ^ m_pulse;
    endfunction

    task automatic check_outputs();
        check("btn_export", button_pio_export, m_stable[NB-1:0]);
        check("sw_export",  switch_pio_export, m_stable[N-1:NB]);
        check("press",      button_press_pulse, m_pulse[NB-1:0] & ~m_stable[NB-1:0]);
        check("release",    button_release_pulse, m_pulse[NB-1:0] & m_stable[NB-1:0]);
        check("sw_change",  switch_change_pulse, m_pulse[N-1:NB]);
        check("any_event",  any_event, |m_pulse);
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model and DUT advance on the edge, compare 1 time unit later,
    // return at the falling edge so the caller can drive the next inputs.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge({sw_raw, btn_raw});
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_reset(input logic v);
        rst = v;
        if (v) model_reset();
        #1;
        check_outputs();
    endtask

    int cnt;

    initial begin
        // 1: reset with button[0] held and all switches on
        rst     = 1'b1;
        btn_raw = 3'b110;
        sw_raw  = 10'h3FF;
        model_reset();
        #1;
        check("t1_btn_export", button_pio_export, 3'b111);
        check("t1_sw_export",  switch_pio_export, 10'h000);
        check("t1_any",        any_event, 1'b0);
        @(negedge clk);
        steps(2);
        rst = 1'b0;
        // Held through reset: accepted 6 edges after deassert, with one pulse
        steps(5);
        check("t1_btn_held_before", button_pio_export, 3'b111);
        step();
        check("t1_btn_held_after",  button_pio_export, 3'b110);
        check("t1_press_pulse",     button_press_pulse, 3'b001);
        check("t1_sw_on",           switch_pio_export, 10'h3FF);
        check("t1_sw_pulse",        switch_change_pulse, 10'h3FF);
        btn_raw = 3'b111;
        sw_raw  = 10'h000;
        steps(10);

        // 2: clean press of button[0]
        btn_raw[0] = 1'b0;
        steps(5);
        check("t2_not_yet", button_pio_export[0], 1'b1);
        step();
        check("t2_export",  button_pio_export[0], 1'b0);
        check("t2_press",   button_press_pulse, 3'b001);
        check("t2_any",     any_event, 1'b1);
        step();
        check("t2_press_off", button_press_pulse, 3'b000);
        check("t2_any_off",   any_event, 1'b0);

        // 3: glitch on button[1] for 3 cycles
        btn_raw[1] = 1'b0;
        steps(3);
        btn_raw[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (any_event || !button_pio_export[1]) cnt++;
        end
        check("t3_glitch_events", cnt, 0);

        // 4: SW[3] bounces every 2 cycles x5, ending high
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            sw_raw[3] = ~sw_raw[3];
            step();
            if (switch_change_pulse[3]) cnt++;
            step();
            if (switch_change_pulse[3]) cnt++;
        end
        steps(3);
        check("t4_not_yet", switch_pio_export[3], 1'b0);
        step();
        check("t4_rise", switch_pio_export[3], 1'b1);
        if (switch_change_pulse[3]) cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            if (switch_change_pulse[3]) cnt++;
        end
        check("t4_one_pulse", cnt, 1);

        // 5: simultaneous events
        btn_raw[2] = 1'b0;
        steps(10);
        btn_raw[2] = 1'b1;
        sw_raw[0]  = 1'b1;
        sw_raw[9]  = 1'b1;
        steps(5);
        step();
        check("t5_sw_pulse",  switch_change_pulse, 10'h201);
        check("t5_release",   button_release_pulse, 3'b100);
        check("t5_any",       any_event, 1'b1);
        step();
        check("t5_any_off",   any_event, 1'b0);

        // 6: reset in the middle of a count
        btn_raw[0] = 1'b1;
        steps(10);
        btn_raw[0] = 1'b0;
        steps(3);
        set_reset(1'b1);
        check("t6_in_reset", button_pio_export, 3'b111);
        @(negedge clk);
        steps(2);
        rst = 1'b0;
        steps(5);
        check("t6_not_yet", button_pio_export[0], 1'b1);
        step();
        check("t6_export", button_pio_export[0], 1'b0);
        check("t6_press",  button_press_pulse[0], 1'b1);
        steps(4);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int idx;
                idx = $urandom_range(0, N - 1);
                if (idx < NB) btn_raw[idx] = ~btn_raw[idx];
                else          sw_raw[idx - NB] = ~sw_raw[idx - NB];
            end
            if (!rst && $urandom_range(0, 299) == 0) begin
                set_reset(1'b1);
                @(negedge clk);
            end else if (rst && $urandom_range(0, 2) == 0) begin
                rst = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
